z80_bus_arbiter: RTL and testbench

Shares the Z80 external bus among up to NUM_MASTERS DMA-style requesters through the CPU's nBUSRQ/nBUSACK handshake. The block sits on the pin side of the CPU, next to the bus fabric. It raises nBUSRQ on behalf of the winning requester, waits for the CPU to float its bus, grants exactly one master, and returns the bus to the CPU when that master is done. Arbitration is round-robin and registered; an optional watchdog limits grant length.

---
 rtl/z80_arb_pkg.sv | 23 ++
 rtl/z80_rr_pick.sv | 46 ++++
 rtl/z80_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_z80_bus_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/z80_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : z80_arb_pkg                                                   |
// | Description : Shared types and default constants for the Z80 bus arbiter.   |
// |               Provides the arbiter state encoding and default parameter     |
// |               values used by z80_bus_arbiter and z80_rr_pick.               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package z80_arb_pkg;

    // Arbiter FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int c_default_num_masters = 4;
    localparam int c_default_max_grant   = 256;

endpackage : z80_arb_pkg
`default_nettype wire

// File: rtl/z80_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : z80_rr_pick                                                   |
// | Description : Combinational round-robin picker. Returns the first set       |
// |               request bit at or after the pointer, wrapping modulo          |
// |               NUM_MASTERS.                                                  |
// | Ports       : req   - request vector                                        |
// |               ptr   - round-robin start position                            |
// |               valid - at least one request is set                           |
// |               index - chosen request index (0 when valid is low)            |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module z80_rr_pick
    import z80_arb_pkg::*;
#(
    parameter int NUM_MASTERS = c_default_num_masters,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    logic [31:0] w_cand;

    // Offsets are scanned from farthest to nearest so the nearest set bit
    // (smallest distance from the pointer) is the last one written and wins.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        w_cand = '0;
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            w_cand = 32'(ptr) + 32'(off);
            if (w_cand >= 32'(NUM_MASTERS)) begin
                w_cand = w_cand - 32'(NUM_MASTERS);
            end
            if (req[w_cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                index = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule : z80_rr_pick
`default_nettype wire

// File: rtl/z80_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : z80_bus_arbiter                                               |
// | Description : Shares the Z80 external bus among NUM_MASTERS requesters      |
// |               using the CPU nBUSRQ/nBUSACK handshake. Registered            |
// |               round-robin arbitration; the CPU regains the bus between      |
// |               every pair of grants (IDLE -> REQ -> GRANT -> RELEASE).       |
// | Options     : define Z80_ARB_TIMEOUT_EN to bound each grant to MAX_GRANT    |
// |               cycles and expose the one-cycle timeout pulse.                |
// | Ports       : CPUCLK  - clock, rising edge                                  |
// |               nRESET  - asynchronous active-low reset                       |
// |               req     - level request per master                            |
// |               gnt     - one-hot-or-zero registered grant                    |
// |               nBUSRQ  - registered bus request to CPU, active-low           |
// |               nBUSACK - bus acknowledge from CPU, active-low                |
// |               busy    - FSM is not in IDLE                                  |
// |               owner   - index of current/last winner                        |
// |               timeout - watchdog expiry pulse (Z80_ARB_TIMEOUT_EN only)     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module z80_bus_arbiter
    import z80_arb_pkg::*;
#(
    parameter int NUM_MASTERS = c_default_num_masters,
    parameter int MAX_GRANT   = c_default_max_grant
) (
    input  logic                           CPUCLK,
    input  logic                           nRESET,
    input  logic [NUM_MASTERS-1:0]         req,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic                           nBUSRQ,
    input  logic                           nBUSACK,
    output logic                           busy,
    output logic [$clog2(NUM_MASTERS)-1:0] owner
`ifdef Z80_ARB_TIMEOUT_EN
    ,
    output logic                           timeout
`endif
);

    localparam int c_idx_w = $clog2(NUM_MASTERS);

    arb_state_t               r_state, w_state_nxt;
    logic [c_idx_w-1:0]       r_ptr, w_ptr_nxt;
    logic [c_idx_w-1:0]       r_owner, w_owner_nxt;
    logic [NUM_MASTERS-1:0]   r_gnt, w_gnt_nxt;
    logic                     r_nbusrq, w_nbusrq_nxt;
    logic                     w_pick_valid;
    logic [c_idx_w-1:0]       w_pick_idx;
    logic                     w_owner_req;

`ifdef Z80_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(MAX_GRANT + 1);
    logic [c_cnt_w-1:0]       r_cnt, w_cnt_nxt;
    logic                     r_timeout, w_timeout_nxt;
    logic                     w_expire;

    // Counter runs 0..MAX_GRANT-1 across the GRANT cycles, so expiring at
    // MAX_GRANT-1 leaves gnt high for exactly MAX_GRANT cycles.
    assign w_expire = (r_cnt == c_cnt_w'(MAX_GRANT - 1));
    assign timeout  = r_timeout;
`else
    logic w_unused_max_grant;
    assign w_unused_max_grant = ^MAX_GRANT;
`endif

    z80_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_idx_w)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .index (w_pick_idx)
    );

    assign w_owner_req = req[r_owner];

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_owner_nxt  = r_owner;
        w_gnt_nxt    = r_gnt;
        w_nbusrq_nxt = r_nbusrq;
`ifdef Z80_ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_owner_nxt  = w_pick_idx;
                    w_nbusrq_nxt = 1'b0;
                    w_state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                // A withdrawn request beats a simultaneous ack: no grant.
                if (!w_owner_req) begin
                    w_nbusrq_nxt = 1'b1;
                    w_state_nxt  = ST_RELEASE;
                end else if (!nBUSACK) begin
                    w_gnt_nxt          = '0;
                    w_gnt_nxt[r_owner] = 1'b1;
                    w_state_nxt        = ST_GRANT;
`ifdef Z80_ARB_TIMEOUT_EN
                    w_cnt_nxt          = '0;
`endif
                end
            end
            ST_GRANT: begin
                // Owner done, or CPU took the bus back without being asked.
                if (!w_owner_req || nBUSACK) begin
                    w_gnt_nxt    = '0;
                    w_nbusrq_nxt = 1'b1;
                    w_state_nxt  = ST_RELEASE;
                end
`ifdef Z80_ARB_TIMEOUT_EN
                else if (w_expire) begin
                    w_gnt_nxt     = '0;
                    w_nbusrq_nxt  = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
`endif
            end
            ST_RELEASE: begin
                if (nBUSACK) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = (r_owner == c_idx_w'(NUM_MASTERS - 1)) ?
                                  '0 : r_owner + c_idx_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CPUCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_gnt     <= '0;
            r_nbusrq  <= 1'b1;
`ifdef Z80_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_gnt     <= w_gnt_nxt;
            r_nbusrq  <= w_nbusrq_nxt;
`ifdef Z80_ARB_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign gnt    = r_gnt;
    assign nBUSRQ = r_nbusrq;
    assign owner  = r_owner;
    assign busy   = (r_state != ST_IDLE);

endmodule : z80_bus_arbiter
`default_nettype wire

// File: tb/tb_z80_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_z80_bus_arbiter                                            |
// | Description : Directed self-checking bench for z80_bus_arbiter with a       |
// |               simple CPU model that answers nBUSRQ on the falling edge.     |
// |               Define Z80_ARB_TIMEOUT_EN to include the watchdog scenario.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_z80_bus_arbiter;

    logic       CPUCLK = 1'b0;
    logic       nRESET = 1'b0;
    logic [3:0] req    = 4'b0000;
    logic [3:0] gnt;
    logic       nBUSRQ;
    logic       nBUSACK = 1'b1;
    logic       busy;
    logic [1:0] owner;
`ifdef Z80_ARB_TIMEOUT_EN
    logic       timeout;
`endif

    logic ack_force_en  = 1'b0;
    logic ack_force_val = 1'b1;

    int checks = 0;
    int errors = 0;

    z80_bus_arbiter #(
        .NUM_MASTERS (4),
        .MAX_GRANT   (8)
    ) dut (
        .CPUCLK  (CPUCLK),
        .nRESET  (nRESET),
        .req     (req),
        .gnt     (gnt),
        .nBUSRQ  (nBUSRQ),
        .nBUSACK (nBUSACK),
        .busy    (busy),
        .owner   (owner)
`ifdef Z80_ARB_TIMEOUT_EN
        ,
        .timeout (timeout)
`endif
    );

    always #5 CPUCLK = ~CPUCLK;

    // CPU model: follows nBUSRQ half a cycle later, so an ack is sampled on
    // the rising edge after nBUSRQ changes. Can be overridden to misbehave.
    always @(negedge CPUCLK) begin
        if (ack_force_en) nBUSACK = ack_force_val;
        else              nBUSACK = nBUSRQ;
    end

    task automatic tick;
        @(posedge CPUCLK);
        #1;
    endtask

    task automatic test_reset;
        nRESET = 1'b0;
        req    = 4'b0000;
        tick();
        tick();
        checks++; if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL reset_nbusrq: got %b expected 1", nBUSRQ); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
`ifdef Z80_ARB_TIMEOUT_EN
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
`endif
        nRESET = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_noreq: busy got %b expected 0", busy); end
    endtask

    task automatic do_reset;
        nRESET = 1'b0;
        req    = 4'b0000;
        tick();
        nRESET = 1'b1;
        tick();
    endtask

    task automatic test_single;
        req = 4'b0010;
        tick();
        checks++; if (nBUSRQ !== 1'b0) begin errors++; $display("FAIL single_busrq: got %b expected 0", nBUSRQ); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_early: got %b expected 0000", gnt); end
        checks++; if (owner !== 2'd1) begin errors++; $display("FAIL single_owner: got %0d expected 1", owner); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %b expected 0010", gnt); end
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt_hold: got %b expected 0010", gnt); end
        req = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop: got %b expected 0000", gnt); end
        checks++; if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL single_busrq_drop: got %b expected 1", nBUSRQ); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_release: got %b expected 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin;
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_gnt = 4'b0001 << exp_seq[i];
            tick();
            checks++; if (owner !== 2'(exp_seq[i])) begin errors++; $display("FAIL rr_owner[%0d]: got %0d expected %0d", i, owner, exp_seq[i]); end
            checks++; if (nBUSRQ !== 1'b0) begin errors++; $display("FAIL rr_busrq_low[%0d]: got %b expected 0", i, nBUSRQ); end
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d.%0d]: got %b expected %b", i, c, gnt, exp_gnt); end
            end
            req[exp_seq[i]] = 1'b0;
            tick();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gnt_off[%0d]: got %b expected 0000", i, gnt); end
            checks++; if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL rr_busrq_high[%0d]: got %b expected 1", i, nBUSRQ); end
            if (i < 4) req[exp_seq[i]] = 1'b1;
            else       req = 4'b0000;
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: busy got %b expected 0", i, busy); end
            checks++; if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL rr_busrq_gap[%0d]: got %b expected 1", i, nBUSRQ); end
        end
    endtask

    task automatic test_abort;
        req = 4'b0100;
        tick();
        checks++; if (owner !== 2'd2) begin errors++; $display("FAIL abort_owner: got %0d expected 2", owner); end
        checks++; if (nBUSRQ !== 1'b0) begin errors++; $display("FAIL abort_busrq: got %b expected 0", nBUSRQ); end
        req = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL abort_gnt: got %b expected 0000", gnt); end
        checks++; if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL abort_busrq_rel: got %b expected 1", nBUSRQ); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_release: busy got %b expected 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b expected 0", busy); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL abort_gnt_idle: got %b expected 0000", gnt); end
        // Pointer now 3: with masters 0 and 3 pending, 3 must win.
        req = 4'b1001;
        tick();
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL abort_ptr: owner got %0d expected 3", owner); end
        req = 4'b0000;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_cleanup: busy got %b expected 0", busy); end
    endtask

    task automatic test_ack_violation;
        req = 4'b0001;
        tick();
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL viol_gnt: got %b expected 0001", gnt); end
        ack_force_val = 1'b1;
        ack_force_en  = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL viol_gnt_clear: got %b expected 0000", gnt); end
        checks++; if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL viol_busrq: got %b expected 1", nBUSRQ); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL viol_idle: busy got %b expected 0", busy); end
        req          = 4'b0000;
        ack_force_en = 1'b0;
        tick();
    endtask

`ifdef Z80_ARB_TIMEOUT_EN
    task automatic test_timeout;
        req = 4'b0001;
        tick();
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL to_owner: got %0d expected 0", owner); end
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_gnt_first: got %b expected 0001", gnt); end
        req = 4'b0011;
        for (int c = 2; c <= 8; c++) begin
            tick();
            checks++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL to_hold[%0d]: gnt %b timeout %b expected 0001 0", c, gnt, timeout); end
        end
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_gnt_cut: got %b expected 0000", gnt); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout); end
        checks++; if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL to_busrq: got %b expected 1", nBUSRQ); end
        tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: busy got %b expected 0", busy); end
        tick();
        checks++; if (owner !== 2'd1) begin errors++; $display("FAIL to_next_owner: got %0d expected 1", owner); end
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_next_gnt: got %b expected 0010", gnt); end
        req = 4'b0000;
        tick();
        tick();
    endtask
`endif

    task automatic test_reset_mid_grant;
        req = 4'b0100;
        tick();
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 0100", gnt); end
        #2;
        nRESET = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_mid_gnt_clear: got %b expected 0000", gnt); end
        checks++; if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL rst_mid_busrq: got %b expected 1", nBUSRQ); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rst_mid_owner: got %0d expected 0", owner); end
        req = 4'b0000;
        tick();
        nRESET = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_ack_violation();
`ifdef Z80_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_z80_bus_arbiter
`default_nettype wire
